// File: rtl/sub_writeback_up.sv
// sub_writeback_up: writeback stage behind the 8-bit subtractor.
// The stage rebuilds the two's-complement difference from the subtractor's
// magnitude and borrow outputs. It queues each result with its destination
// address in a small FIFO. A two-state FSM presents the head entry to the
// register file and holds it until wr_ack. Z/N/C flags update as each write
// retires.
// Optional feature: define SUB_WB_SATURATE_EN to clamp negative results to
// zero at push time. flag_c still reports the borrow for a clamped entry.

module sub_writeback_up #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        sub_out_in,
   input  logic                     bi_sub_in,
   input  logic [ADDR_W-1:0]        dst_addr_in,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_ack,
   output logic                     flag_z,
   output logic                     flag_n,
   output logic                     flag_c,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_s;

   logic [DATA_W-1:0]   data_mem_r [DEPTH];
   logic                bi_mem_r   [DEPTH];
   logic [ADDR_W-1:0]   addr_mem_r [DEPTH];

   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic [CNT_W-1:0]    count_nxt_s;

   logic                flag_z_r;
   logic                flag_n_r;
   logic                flag_c_r;

   logic                full_s;
   logic                push_s;
   logic                pop_s;

   // Value written to the register file for one subtractor result. Without
   // clamping, a borrow means the magnitude is negated, which also covers the
   // subtractor's rd=0 case (251 with borrow becomes 5).
   function automatic logic [DATA_W-1:0] wb_data(input logic [DATA_W-1:0] mag,
                                                 input logic              bi);
`ifdef SUB_WB_SATURATE_EN
      if (bi) begin
         return {DATA_W{1'b0}};
      end else begin
         return mag;
      end
`else
      if (bi) begin
         return (~mag) + DATA_W'(1);
      end else begin
         return mag;
      end
`endif
   endfunction

   assign full_s      = (count_r == CNT_W'(DEPTH));
   assign in_ready    = ~full_s;
   assign push_s      = in_valid & ~full_s;
   assign pop_s       = (state_r == ISSUE) & wr_ack;
   assign count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

   assign busy   = (count_r != {CNT_W{1'b0}}) | (state_r != IDLE);
   assign count  = count_r;
   assign flag_z = flag_z_r;
   assign flag_n = flag_n_r;
   assign flag_c = flag_c_r;

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // FIFO storage. A push never targets the head slot while a pop reads it:
   // that would need the FIFO to be empty or full, and neither case allows
   // both a push and a pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_r[i] <= {DATA_W{1'b0}};
            bi_mem_r[i]   <= 1'b0;
            addr_mem_r[i] <= {ADDR_W{1'b0}};
         end
      end else if (push_s) begin
         data_mem_r[wr_ptr_r] <= wb_data(sub_out_in, bi_sub_in);
         bi_mem_r[wr_ptr_r]   <= bi_sub_in;
         addr_mem_r[wr_ptr_r] <= dst_addr_in;
      end
   end

   // Status flags follow the entry that retires; pushes leave them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_z_r <= 1'b0;
         flag_n_r <= 1'b0;
         flag_c_r <= 1'b0;
      end else if (pop_s) begin
         flag_z_r <= (data_mem_r[rd_ptr_r] == {DATA_W{1'b0}});
         flag_n_r <= data_mem_r[rd_ptr_r][DATA_W-1];
         flag_c_r <= bi_mem_r[rd_ptr_r];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state: leave IDLE once something is queued. Keep issuing while
   // entries remain after this cycle's pop and push.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (count_r != {CNT_W{1'b0}}) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (wr_ack) begin
               if (count_nxt_s != {CNT_W{1'b0}}) begin
                  state_s = ISSUE;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = ISSUE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs: the head entry is presented only while issuing, else zeros.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
      case (state_r)
         ISSUE: begin
            wr_en   = 1'b1;
            wr_addr = addr_mem_r[rd_ptr_r];
            wr_data = data_mem_r[rd_ptr_r];
         end
         IDLE: begin
            wr_en   = 1'b0;
            wr_addr = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
         end
         default: begin
            wr_en   = 1'b0;
            wr_addr = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
         end
      endcase
   end

endmodule
